median_line_buffer: RTL and testbench

MEDIAN_LINE_BUFFER -- requirements
Module: median_line_buffer

---
 rtl/median_pkg.sv | 20 ++
 rtl/median_line_buffer_if.sv | 32 +++
 rtl/median_line_ram.sv | 46 ++++
 rtl/median_line_buffer.sv | 116 +++++++++++
 tb/tb_median_line_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median filter datapath: default geometry,
// line-buffer row-fill states and the column-index width helper.
package median_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned IMG_WIDTH_DEF = 64;

    // How many complete lines the buffer currently holds for this frame.
    typedef enum logic [1:0] {
        ROW_0    = 2'd0,
        ROW_1    = 2'd1,
        ROW_FULL = 2'd2
    } row_state_e;

    // Bits needed to index one column of a line.
    function automatic int unsigned col_w(input int unsigned img_width);
        return (img_width > 1) ? $clog2(img_width) : 1;
    endfunction

endpackage

// File: rtl/median_line_buffer_if.sv
// Pixel stream in / vertical tap column out for the median line buffer.
//   sof, pix_valid, pix_in     : raster pixel stream (master -> slave)
//   x2_y1, x2_y0, x2_ym1       : column taps rows r, r-1, r-2 (slave -> master)
//   win_valid, col_out         : tap column complete / its column index
interface median_line_buffer_if
    import median_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF
);
    localparam int unsigned COL_W = col_w(IMG_WIDTH);

    logic              sof;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_in;
    logic [DATA_W-1:0] x2_y1;
    logic [DATA_W-1:0] x2_y0;
    logic [DATA_W-1:0] x2_ym1;
    logic              win_valid;
    logic [COL_W-1:0]  col_out;

    modport master (
        output sof, pix_valid, pix_in,
        input  x2_y1, x2_y0, x2_ym1, win_valid, col_out
    );

    modport slave (
        input  sof, pix_valid, pix_in,
        output x2_y1, x2_y0, x2_ym1, win_valid, col_out
    );

endinterface

// File: rtl/median_line_ram.sv
// Single-port read-first synchronous line RAM, DEPTH x DATA_W.
//   clk, rst  : clock, synchronous active-high reset (output register only)
//   en_i      : access strobe; read and optional write share addr_i
//   addr_i    : word address
//   wdata_i   : write data, written whenever en_i is high
//   rdata_o   : registered old word at addr_i, updated only on en_i
//   rdata_c   : old word at addr_i this cycle, for cascading into a second line
module median_line_ram
    import median_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = IMG_WIDTH_DEF,
    localparam int unsigned ADDR_W = col_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    assign rdata_c = mem_q[addr_i];
    assign rdata_o = rdata_q;

    // Storage is never reset; the row counter upstream masks stale contents.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-first: the register captures the word before this cycle's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/median_line_buffer.sv
// Two-line buffer producing a 3-tap vertical pixel column for the median filter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of median_line_buffer_if (pixel stream in, taps out)
// Taps appear one cycle after the accepted pixel; win_valid marks columns whose
// three rows all belong to the current frame.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    median_line_buffer_if.slave  bus
);

    localparam int unsigned      COL_W    = col_w(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    row_state_e        row_q, row_d, row_cur_c;
    logic [COL_W-1:0]  col_q, col_d, col_cur_c;
    logic [COL_W-1:0]  col_out_q, col_out_d;
    logic              win_q, win_d;
    logic [DATA_W-1:0] y1_q, y1_d;
    logic              accept_c;
    logic [DATA_W-1:0] line1_old_c;
    logic [DATA_W-1:0] line2_old_unused;
    logic [DATA_W-1:0] y0_rd;
    logic [DATA_W-1:0] ym1_rd;

    // A pixel in a reset cycle is discarded and must not touch the lines.
    assign accept_c = bus.pix_valid & ~rst;

    // Counter position for this pixel (sof restarts it) and next-state logic.
    always_comb begin
        col_cur_c = col_q;
        row_cur_c = row_q;
        col_d     = col_q;
        row_d     = row_q;
        col_out_d = col_out_q;
        y1_d      = y1_q;
        win_d     = 1'b0;
        if (bus.pix_valid) begin
            if (bus.sof) begin
                col_cur_c = '0;
                row_cur_c = ROW_0;
            end
            y1_d      = bus.pix_in;
            col_out_d = col_cur_c;
            win_d     = (row_cur_c == ROW_FULL);
            if (col_cur_c == COL_LAST) begin
                col_d = '0;
                unique case (row_cur_c)
                    ROW_0:   row_d = ROW_1;
                    ROW_1:   row_d = ROW_FULL;
                    default: row_d = ROW_FULL;
                endcase
            end else begin
                col_d = col_cur_c + COL_W'(1);
                row_d = row_cur_c;
            end
        end
    end

    // State and tap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= ROW_0;
            col_q     <= '0;
            col_out_q <= '0;
            win_q     <= 1'b0;
            y1_q      <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            win_q     <= win_d;
            y1_q      <= y1_d;
        end
    end

    // Line r-1: takes the new pixel, hands its old word down to line r-2.
    median_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) u_line1 (
        .clk     (clk),
        .rst     (rst),
        .en_i    (accept_c),
        .addr_i  (col_cur_c),
        .wdata_i (bus.pix_in),
        .rdata_o (y0_rd),
        .rdata_c (line1_old_c)
    );

    // Line r-2.
    median_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) u_line2 (
        .clk     (clk),
        .rst     (rst),
        .en_i    (accept_c),
        .addr_i  (col_cur_c),
        .wdata_i (line1_old_c),
        .rdata_o (ym1_rd),
        .rdata_c (line2_old_unused)
    );

    assign bus.x2_y1     = y1_q;
    assign bus.x2_y0     = y0_rd;
    assign bus.x2_ym1    = ym1_rd;
    assign bus.win_valid = win_q;
    assign bus.col_out   = col_out_q;

endmodule

// File: tb/tb_median_line_buffer.sv
// Self-checking bench for median_line_buffer: a directed vector table on a
// 4-pixel-wide instance, hand-written sof/reset sequences, and a 1024-wide
// instance checked against a small line-buffer model with random pixels.
module tb_median_line_buffer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    median_line_buffer_if #(.DATA_W(8), .IMG_WIDTH(4))    bus4 ();
    median_line_buffer_if #(.DATA_W(8), .IMG_WIDTH(1024)) bus1k ();

    median_line_buffer #(.DATA_W(8), .IMG_WIDTH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    median_line_buffer #(.DATA_W(8), .IMG_WIDTH(1024)) u1k (
        .clk (clk),
        .rst (rst),
        .bus (bus1k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sof;
        logic       valid;
        logic [7:0] pix;
        logic       e_win;
        logic [7:0] e_y1;
        logic [7:0] e_y0;
        logic [7:0] e_ym1;
        logic [1:0] e_col;
        logic       chk_taps;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] rowv[3];
    logic [7:0] m1[1024];
    logic [7:0] m2[1024];

    function automatic vec_t mk(input logic sof, input logic valid, input logic [7:0] pix,
                                input logic e_win, input logic [7:0] e_y1, input logic [7:0] e_y0,
                                input logic [7:0] e_ym1, input logic [1:0] e_col, input logic chk_taps);
        vec_t v;
        v.sof = sof; v.valid = valid; v.pix = pix; v.e_win = e_win;
        v.e_y1 = e_y1; v.e_y0 = e_y0; v.e_ym1 = e_ym1; v.e_col = e_col; v.chk_taps = chk_taps;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle on the 4-wide instance and sample just after the edge.
    task automatic px(input logic sof, input logic valid, input logic [7:0] pix);
        bus4.sof       = sof;
        bus4.pix_valid = valid;
        bus4.pix_in    = pix;
        @(posedge clk);
        #1;
        bus4.sof       = 1'b0;
        bus4.pix_valid = 1'b0;
    endtask

    task automatic chk4(input string nm, input logic e_win, input logic [7:0] e_y1,
                        input logic [7:0] e_y0, input logic [7:0] e_ym1, input logic [1:0] e_col);
        chk({nm, " win"}, 32'(bus4.win_valid), 32'(e_win));
        chk({nm, " y1"},  32'(bus4.x2_y1),     32'(e_y1));
        chk({nm, " y0"},  32'(bus4.x2_y0),     32'(e_y0));
        chk({nm, " ym1"}, 32'(bus4.x2_ym1),    32'(e_ym1));
        chk({nm, " col"}, 32'(bus4.col_out),   32'(e_col));
    endtask

    initial begin
        logic [7:0] p;
        int         pulses;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus4.sof = 1'b0;  bus4.pix_valid = 1'b0;  bus4.pix_in = '0;
        bus1k.sof = 1'b0; bus1k.pix_valid = 1'b0; bus1k.pix_in = '0;
        rowv[0] = 8'h0C; rowv[1] = 8'h20; rowv[2] = 8'h80;

        // Phase A: constant rows, continuous valid, no sof on the first pixel.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                vecs.push_back(mk(1'b0, 1'b1, rowv[r], r == 2, rowv[r], 8'h20, 8'h0C, 2'(c), r == 2));
        // Phase B: same rows with a gap after every pixel; one gap carries a stray sof.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                vecs.push_back(mk(r == 0 && c == 0, 1'b1, rowv[r], r == 2, rowv[r], 8'h20, 8'h0C, 2'(c), r == 2));
                vecs.push_back(mk(r == 1 && c == 3, 1'b0, 8'hEE, 1'b0, rowv[r], 8'h20, 8'h0C, 2'(c), r == 2));
            end
        // Phase C: pixel = row*16+col over five rows.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++) begin
                p = 8'(r * 16 + c);
                vecs.push_back(mk(r == 0 && c == 0, 1'b1, p, r >= 2, p, 8'(p - 8'h10), 8'(p - 8'h20), 2'(c), r >= 2));
            end

        // Reset, with a pixel offered that must be discarded.
        bus4.pix_valid = 1'b1; bus4.pix_in = 8'h77; bus4.sof = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk4("reset", 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        chk("reset 1k win", 32'(bus1k.win_valid), 32'd0);
        chk("reset 1k col", 32'(bus1k.col_out), 32'd0);
        rst = 1'b0;
        bus4.pix_valid = 1'b0; bus4.sof = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            px(vecs[i].sof, vecs[i].valid, vecs[i].pix);
            chk($sformatf("vec%0d win", i), 32'(bus4.win_valid), 32'(vecs[i].e_win));
            chk($sformatf("vec%0d y1", i),  32'(bus4.x2_y1),     32'(vecs[i].e_y1));
            if (vecs[i].chk_taps) begin
                chk($sformatf("vec%0d y0", i),  32'(bus4.x2_y0),  32'(vecs[i].e_y0));
                chk($sformatf("vec%0d ym1", i), 32'(bus4.x2_ym1), 32'(vecs[i].e_ym1));
            end
            if (vecs[i].e_win)
                chk($sformatf("vec%0d col", i), 32'(bus4.col_out), 32'(vecs[i].e_col));
        end

        // sof at row 3, col 1 restarts the frame.
        for (int k = 0; k < 13; k++) px(k == 0, 1'b1, 8'(8'h30 + k));
        chk("sofseq row3c0 win", 32'(bus4.win_valid), 32'd1);
        px(1'b1, 1'b1, 8'h50);
        chk("sofseq restart win", 32'(bus4.win_valid), 32'd0);
        chk("sofseq restart col", 32'(bus4.col_out), 32'd0);
        for (int k = 1; k < 8; k++) begin
            if (k == 4) px(1'b1, 1'b0, 8'hEE);
            px(1'b0, 1'b1, 8'(8'h50 + k));
            chk($sformatf("sofseq k%0d win", k), 32'(bus4.win_valid), 32'd0);
        end
        px(1'b0, 1'b1, 8'h58);
        chk4("sofseq first win", 1'b1, 8'h58, 8'h54, 8'h50, 2'd0);

        // Reset mid row 2 with a valid pixel in the reset cycle.
        for (int k = 0; k < 10; k++) px(k == 0, 1'b1, 8'(8'h90 + k));
        chk4("rstseq pre", 1'b1, 8'h99, 8'h95, 8'h91, 2'd1);
        rst = 1'b1;
        px(1'b0, 1'b1, 8'hFF);
        chk4("rstseq in reset", 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            px(1'b0, 1'b1, 8'(8'hA0 + k));
            chk($sformatf("rstseq k%0d win", k), 32'(bus4.win_valid), 32'd0);
        end
        px(1'b0, 1'b1, 8'hA8);
        chk4("rstseq first win", 1'b1, 8'hA8, 8'hA4, 8'hA0, 2'd0);
        px(1'b0, 1'b0, 8'h00);
        chk4("rstseq hold", 1'b0, 8'hA8, 8'hA4, 8'hA0, 2'd0);

        // 1024-wide instance, three lines of random pixels against a model.
        pulses = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 1024; c++) begin
                p = 8'($urandom_range(0, 255));
                bus1k.pix_valid = 1'b1;
                bus1k.pix_in    = p;
                @(posedge clk);
                #1;
                bus1k.pix_valid = 1'b0;
                if (bus1k.win_valid === 1'b1) pulses++;
                chk($sformatf("big r%0d c%0d win", r, c), 32'(bus1k.win_valid), 32'(r == 2));
                chk($sformatf("big r%0d c%0d y1", r, c), 32'(bus1k.x2_y1), 32'(p));
                if (r == 2) begin
                    chk($sformatf("big c%0d y0", c),  32'(bus1k.x2_y0),   32'(m1[c]));
                    chk($sformatf("big c%0d ym1", c), 32'(bus1k.x2_ym1),  32'(m2[c]));
                    chk($sformatf("big c%0d col", c), 32'(bus1k.col_out), 32'(c));
                end
                m2[c] = m1[c];
                m1[c] = p;
            end
        @(posedge clk);
        #1;
        chk("big idle win", 32'(bus1k.win_valid), 32'd0);
        chk("big pulse count", 32'(pulses), 32'd1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
